fetch_buffer: RTL
=================

# fetch_buffer

Instruction fetch buffer sitting directly downstream of the instruction cache and upstream of the decoder. It requests 64-byte aligned lines from the cache, holds up to two consecutive lines, and presents a byte window starting at the current fetch PC to the decoder. The decoder reports how many bytes it consumed each cycle. A redirect flushes the buffer and restarts fetch at an arbitrary byte address.

## Interface
- FETCH_BYTES, 16, decoder window width in bytes (power of two, ≤ 64)
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  64  new fetch PC, any byte alignment
- ic_enable  out  1  one-cycle request pulse to the cache
- ic_addr  out  64  request address, always 64-byte aligned
- ic_rdata  in  512  returned line; byte k = ic_rdata[8k+7:8k]
- ic_done  in  1  one-cycle pulse, ic_rdata valid this cycle
- dec_pc  out  64  address of dec_bytes byte 0
- dec_bytes  out  8*FETCH_BYTES  bytes at dec_pc.., byte k in bits [8k+7:8k]
- dec_count  out  $clog2(FETCH_BYTES)+1  number of valid bytes in dec_bytes (0..FETCH_BYTES)
- dec_consume  in  $clog2(FETCH_BYTES)+1  bytes consumed this cycle, ≤ dec_count

## Operation
- Storage: two 512-bit line slots; line at address A lives in slot A[6]; per-slot valid bit and tag (A[63:6]).
- Registers: dec_pc, fetch_addr (next line to request, aligned), started flag, FSM.
- FSM states: IDLE (no request outstanding), WAIT (request outstanding, keep data), WAIT_DROP (request outstanding, discard data).
- IDLE: if started and slot fetch_addr[6] invalid → ic_enable<=1, ic_addr<=fetch_addr, go WAIT.
- WAIT: ic_enable<=0; on ic_done → write ic_rdata to slot ic_addr[6], set valid, fetch_addr+=64, go IDLE.
- WAIT_DROP: ic_enable<=0; on ic_done → discard data, go IDLE (fetch_addr already points at redirect line).
- Redirect: clear both valids, dec_pc<=redirect_pc, fetch_addr<=redirect_pc & ~63, started<=1; WAIT→WAIT_DROP; WAIT_DROP stays; IDLE stays IDLE.
- dec_count = min(FETCH_BYTES, avail); avail = 0 if current slot (dec_pc[6]) invalid or tag mismatch, else 64−dec_pc[5:0], plus 64 if the other slot holds line dec_pc[63:6]+1.
- dec_bytes byte k = buffer byte (dec_pc[6:0]+k) mod 128 for k < dec_count; bytes k ≥ dec_count driven 0.
- Consume: dec_pc += dec_consume (mod 2^64); if dec_pc crosses a 64-byte boundary, the old slot's valid clears.
- dec_consume > dec_count is illegal: assertion with $fatal.
- Simultaneous events: redirect overrides consume and any same-cycle ic_done data (line dropped, FSM→IDLE since request completes); ic_done with a consume that frees a slot both take effect.
- Before the first redirect after reset, no requests are issued.

## Timing
- Reset values: ic_enable 0, ic_addr 0, dec_pc 0, dec_count 0, dec_bytes 0; FSM IDLE, valids 0, started 0, fetch_addr 0.
- dec_* outputs are combinational from registers only (no input→output paths).
- Redirect at edge N → dec_count 0 in cycle N+1; ic_enable at earliest edge N+1 (IDLE case).
- ic_enable is high exactly one cycle per request; never high while a request is outstanding.
- ic_done at edge M → data visible on dec_bytes cycle M+1; next ic_enable no earlier than edge M+1.
- Consume at edge N → new dec_pc and freed slot visible in cycle N+1; a request into the freed slot may issue at edge N+1.
- Reset asserted mid-request: all state cleared immediately; a later stray ic_done is ignored in IDLE.

## Test plan
- Reset, redirect to 0x1000; cache returns line bytes 0x00..0x3F → ic_addr 0x1000, then dec_count 16, dec_bytes = 0x00..0x0F, second request ic_addr 0x1040.
- Redirect 0x103A; only first line returned → dec_count 6 (bytes 0x3A..0x3F); after 0x1040 line returns → dec_count 16, bytes span both lines.
- Steady consume 16/cycle from 0x1000 → crossing 0x1040 frees slot 0, request 0x1080 issued; dec_pc sequence 0x1000, 0x1010, ...
- Redirect to 0x2000 while 0x1040 outstanding → returning line discarded, dec_count stays 0, next ic_addr 0x2000.
- Redirect, ic_done and dec_consume=4 same cycle → dec_pc = redirect_pc, dec_count 0, line dropped.
- Both slots full, dec_consume 0 for 20 cycles → no ic_enable; one consume across boundary → exactly one request.

Source files
------------

// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction fetch buffer between the instruction cache and the decoder.
// Holds up to two consecutive 64-byte lines (line at address A lives in slot A[6]) and presents
// a FETCH_BYTES-wide byte window starting at the current fetch PC.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   redirect(_pc)       flush buffer and restart fetch at redirect_pc (any byte alignment)
//   ic_enable, ic_addr  one-cycle line request pulse and its 64-byte aligned address
//   ic_rdata, ic_done   returned line and its one-cycle valid pulse
//   dec_pc              address of dec_bytes byte 0
//   dec_bytes           window bytes, byte k in bits [8k+7:8k]; bytes beyond dec_count are 0
//   dec_count           number of valid window bytes (0..FETCH_BYTES)
//   dec_consume         bytes consumed by the decoder this cycle (<= dec_count)
module fetch_buffer #(
   parameter int unsigned FETCH_BYTES = 16,
   localparam int unsigned CW = $clog2(FETCH_BYTES) + 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     redirect,
   input  logic [63:0]              redirect_pc,
   output logic                     ic_enable,
   output logic [63:0]              ic_addr,
   input  logic [511:0]             ic_rdata,
   input  logic                     ic_done,
   output logic [63:0]              dec_pc,
   output logic [8*FETCH_BYTES-1:0] dec_bytes,
   output logic [CW-1:0]            dec_count,
   input  logic [CW-1:0]            dec_consume
);

   localparam logic [1:0] StIdle     = 2'd0;
   localparam logic [1:0] StWait     = 2'd1;
   localparam logic [1:0] StWaitDrop = 2'd2;

   logic [1:0]   state_q, state_d;
   logic [1:0]   valid_q, valid_d;
   logic [57:0]  tag_q [2];
   logic [57:0]  tag_d [2];
   logic [511:0] line_q [2];
   logic [63:0]  dec_pc_q, dec_pc_d;
   logic [63:0]  fetch_addr_q, fetch_addr_d;
   logic         started_q, started_d;
   logic         ic_enable_q, ic_enable_d;
   logic [63:0]  ic_addr_q, ic_addr_d;
   logic         line_we;
   logic [63:0]  consume_pc;

   // ---------------------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      tag_d        = tag_q;
      dec_pc_d     = dec_pc_q;
      fetch_addr_d = fetch_addr_q;
      started_d    = started_q;
      ic_enable_d  = 1'b0;
      ic_addr_d    = ic_addr_q;
      line_we      = 1'b0;
      consume_pc   = dec_pc_q + 64'(dec_consume);

      // Consume first so a same-cycle fill into the other slot is not disturbed.
      if (dec_consume != '0) begin
         dec_pc_d = consume_pc;
         if (consume_pc[63:6] != dec_pc_q[63:6]) begin
            valid_d[dec_pc_q[6]] = 1'b0;
         end
      end

      case (state_q)
         StIdle: begin
            if (started_q && !valid_q[fetch_addr_q[6]]) begin
               ic_enable_d = 1'b1;
               ic_addr_d   = fetch_addr_q;
               state_d     = StWait;
            end
         end
         StWait: begin
            if (ic_done) begin
               line_we                = 1'b1;
               valid_d[ic_addr_q[6]]  = 1'b1;
               tag_d[ic_addr_q[6]]    = ic_addr_q[63:6];
               fetch_addr_d           = fetch_addr_q + 64'd64;
               state_d                = StIdle;
            end
         end
         StWaitDrop: begin
            // fetch_addr already points at the redirect line; just retire the stale request.
            if (ic_done) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Redirect wins over consume, fills and new requests.
      if (redirect) begin
         valid_d      = 2'b00;
         dec_pc_d     = redirect_pc;
         fetch_addr_d = {redirect_pc[63:6], 6'd0};
         started_d    = 1'b1;
         ic_enable_d  = 1'b0;
         ic_addr_d    = ic_addr_q;
         line_we      = 1'b0;
         if (state_q == StIdle || ic_done) begin
            state_d = StIdle;
         end else begin
            state_d = StWaitDrop;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         valid_q      <= 2'b00;
         tag_q[0]     <= '0;
         tag_q[1]     <= '0;
         dec_pc_q     <= '0;
         fetch_addr_q <= '0;
         started_q    <= 1'b0;
         ic_enable_q  <= 1'b0;
         ic_addr_q    <= '0;
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         tag_q        <= tag_d;
         dec_pc_q     <= dec_pc_d;
         fetch_addr_q <= fetch_addr_d;
         started_q    <= started_d;
         ic_enable_q  <= ic_enable_d;
         ic_addr_q    <= ic_addr_d;
      end
   end

   // Line data needs no reset: it is only visible through a set valid bit.
   always_ff @(posedge clk) begin
      if (line_we) begin
         line_q[ic_addr_q[6]] <= ic_rdata;
      end
   end

   // ---------------------------------------------------------------------------------------
   // Decoder window (registers only)
   // ---------------------------------------------------------------------------------------
   logic         cur_slot;
   logic         cur_ok;
   logic         nxt_ok;
   logic [7:0]   avail;
   logic [1023:0] buf_w;
   logic [6:0]   idx;

   always_comb begin
      cur_slot = dec_pc_q[6];
      cur_ok   = valid_q[cur_slot] && (tag_q[cur_slot] == dec_pc_q[63:6]);
      nxt_ok   = valid_q[~cur_slot] && (tag_q[~cur_slot] == dec_pc_q[63:6] + 58'd1);
      avail    = 8'd0;
      if (cur_ok) begin
         avail = 8'd64 - {2'b00, dec_pc_q[5:0]} + (nxt_ok ? 8'd64 : 8'd0);
      end
      dec_count = (32'(avail) > FETCH_BYTES) ? CW'(FETCH_BYTES) : CW'(avail);

      // Slots form a 128-byte ring indexed by address bits [6:0].
      buf_w     = {line_q[1], line_q[0]};
      dec_bytes = '0;
      idx       = '0;
      for (int k = 0; k < int'(FETCH_BYTES); k++) begin
         idx = dec_pc_q[6:0] + 7'(k);
         if (32'(k) < 32'(dec_count)) begin
            dec_bytes[8*k +: 8] = buf_w[{idx, 3'b000} +: 8];
         end
      end
   end

   assign dec_pc    = dec_pc_q;
   assign ic_enable = ic_enable_q;
   assign ic_addr   = ic_addr_q;

   // Decoder must never take more than it was offered.
   assert property (@(posedge clk) disable iff (!reset_n) dec_consume <= dec_count)
      else $fatal(1, "dec_consume exceeds dec_count");

endmodule
